// File: rtl/match_ctrl.sv
// Match sequencer for a paddle game: serve delay, play, point hold, pause and win detection.
// All outputs come from flops; ball_enable and game_over decode the registered state.
module match_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 10,
  parameter int WIN_BY_TWO   = 0,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           frame_tick,
  input  logic [NUM_PLAYERS-1:0]         score_pulse,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           round_reset,
  output logic                           ball_enable,
  output logic                           game_over,
  output logic [1:0]                     winner,
  output logic [2:0]                     state
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    POINT  = 3'd3,
    PAUSED = 3'd4,
    OVER   = 3'd5
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
  logic                           round_reset_q, round_reset_d;
  logic [1:0]                     winner_q, winner_d;

  logic                           win_found;
  logic [1:0]                     win_idx;
  logic                           cand;
  int                             si;
  int                             pidx;
  logic [SCORE_W-1:0]             cur_score;

  // Scanning from the top down lets the lowest qualifying player overwrite the result.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 1'b0;
    si        = 0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      si   = int'(scores_q[i*SCORE_W +: SCORE_W]);
      cand = (si >= WIN_SCORE);
      if (WIN_BY_TWO != 0) begin
        for (int j = 0; j < NUM_PLAYERS; j++) begin
          if (j != i && si < int'(scores_q[j*SCORE_W +: SCORE_W]) + 2) cand = 1'b0;
        end
      end
      if (cand) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    pidx = 0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (score_pulse[i]) pidx = i;
    end
    cur_score = scores_q[pidx*SCORE_W +: SCORE_W];
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    scores_d      = scores_q;
    round_reset_d = 1'b0;
    winner_d      = winner_q;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          scores_d      = '0;
          round_reset_d = 1'b1;
          state_d       = SERVE;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) state_d = PLAY;
          else                                   cnt_d   = cnt_q + 1'b1;
        end
      end
      PLAY: begin
        if (|score_pulse) begin
          if (!(&cur_score)) scores_d[pidx*SCORE_W +: SCORE_W] = cur_score + 1'b1;
          state_d = POINT;
        end else if (pause) begin
          state_d = PAUSED;
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(POINT_FRAMES - 1)) begin
            if (win_found) begin
              state_d  = OVER;
              winner_d = win_idx;
            end else begin
              state_d       = SERVE;
              round_reset_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PAUSED: begin
        if (pause) state_d = PLAY;
      end
      default: state_d = IDLE;
    endcase
    // Every state entry restarts the frame count, so a tick in the transition cycle is dropped.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      scores_q      <= '0;
      round_reset_q <= 1'b0;
      winner_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      scores_q      <= scores_d;
      round_reset_q <= round_reset_d;
      winner_q      <= winner_d;
    end
  end

  assign scores      = scores_q;
  assign round_reset = round_reset_q;
  assign winner      = winner_q;
  assign state       = state_q;
  assign ball_enable = (state_q == PLAY);
  assign game_over   = (state_q == OVER);

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: three parameterisations checked every cycle against a rule-level model,
// plus hand-computed checkpoints along directed match scripts.
module tb_match_ctrl;

  localparam int P_SW[3]  = '{4, 4, 2};
  localparam int P_WIN[3] = '{10, 3, 3};
  localparam int P_WB2[3] = '{0, 1, 1};
  localparam int P_SF[3]  = '{60, 2, 2};
  localparam int P_PF[3]  = '{30, 2, 2};

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;
  logic [2:0] st  = '0;
  logic [2:0] pa  = '0;
  logic [2:0] ft  = '0;
  logic [1:0] sp [3];

  logic [7:0] o_sc0, o_sc1;
  logic [3:0] o_sc2;
  logic [2:0] o_state [3];
  logic       o_rr [3];
  logic       o_be [3];
  logic       o_go [3];
  logic [1:0] o_win [3];

  int n_vec = 0;
  int n_bad = 0;
  int rr_cnt[3] = '{0, 0, 0};

  int m_mode[3];
  int m_tk[3];
  int m_rr[3];
  int m_win[3];
  int m_sc[3][2];

  always #5 clk = ~clk;

  match_ctrl u0 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .pause(pa[0]), .frame_tick(ft[0]),
    .score_pulse(sp[0]), .scores(o_sc0), .round_reset(o_rr[0]), .ball_enable(o_be[0]),
    .game_over(o_go[0]), .winner(o_win[0]), .state(o_state[0])
  );

  match_ctrl #(.NUM_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(3), .WIN_BY_TWO(1),
               .SERVE_FRAMES(2), .POINT_FRAMES(2)) u1 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .pause(pa[1]), .frame_tick(ft[1]),
    .score_pulse(sp[1]), .scores(o_sc1), .round_reset(o_rr[1]), .ball_enable(o_be[1]),
    .game_over(o_go[1]), .winner(o_win[1]), .state(o_state[1])
  );

  match_ctrl #(.NUM_PLAYERS(2), .SCORE_W(2), .WIN_SCORE(3), .WIN_BY_TWO(1),
               .SERVE_FRAMES(2), .POINT_FRAMES(2)) u2 (
    .clk(clk), .reset(rst[2]), .start(st[2]), .pause(pa[2]), .frame_tick(ft[2]),
    .score_pulse(sp[2]), .scores(o_sc2), .round_reset(o_rr[2]), .ball_enable(o_be[2]),
    .game_over(o_go[2]), .winner(o_win[2]), .state(o_state[2])
  );

  function automatic logic [31:0] d_score(int k, int p);
    case (k)
      0:       return 32'(o_sc0[p*4 +: 4]);
      1:       return 32'(o_sc1[p*4 +: 4]);
      default: return 32'(o_sc2[p*2 +: 2]);
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns the index of the player that has won, or -1.
  function automatic int model_winner(int k);
    for (int i = 0; i < 2; i++) begin
      if (m_sc[k][i] >= P_WIN[k] &&
          (P_WB2[k] == 0 || m_sc[k][i] >= m_sc[k][1-i] + 2)) return i;
    end
    return -1;
  endfunction

  task automatic model_step(int k);
    int nm;
    int p;
    int w;
    if (rst[k]) begin
      m_mode[k] = 0; m_tk[k] = 0; m_rr[k] = 0; m_win[k] = 0;
      m_sc[k][0] = 0; m_sc[k][1] = 0;
      return;
    end
    nm = m_mode[k];
    m_rr[k] = 0;
    case (m_mode[k])
      0, 5: if (st[k]) begin
        m_sc[k][0] = 0; m_sc[k][1] = 0; m_rr[k] = 1; nm = 1;
      end
      1: if (ft[k]) begin
        m_tk[k]++;
        if (m_tk[k] == P_SF[k]) nm = 2;
      end
      2: if (sp[k] != 2'b00) begin
        p = sp[k][0] ? 0 : 1;
        if (m_sc[k][p] < (1 << P_SW[k]) - 1) m_sc[k][p]++;
        nm = 3;
      end else if (pa[k]) begin
        nm = 4;
      end
      3: if (ft[k]) begin
        m_tk[k]++;
        if (m_tk[k] == P_PF[k]) begin
          w = model_winner(k);
          if (w >= 0) begin nm = 5; m_win[k] = w; end
          else begin nm = 1; m_rr[k] = 1; end
        end
      end
      4: if (pa[k]) nm = 2;
      default: nm = 0;
    endcase
    if (nm != m_mode[k]) m_tk[k] = 0;
    m_mode[k] = nm;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d state", k), 32'(o_state[k]), 32'(m_mode[k]));
        chk($sformatf("u%0d ball_enable", k), 32'(o_be[k]), 32'(m_mode[k] == 2));
        chk($sformatf("u%0d game_over", k), 32'(o_go[k]), 32'(m_mode[k] == 5));
        chk($sformatf("u%0d round_reset", k), 32'(o_rr[k]), 32'(m_rr[k]));
        chk($sformatf("u%0d score0", k), d_score(k, 0), 32'(m_sc[k][0]));
        chk($sformatf("u%0d score1", k), d_score(k, 1), 32'(m_sc[k][1]));
        if (m_mode[k] == 5) chk($sformatf("u%0d winner", k), 32'(o_win[k]), 32'(m_win[k]));
        if (o_rr[k] === 1'b1) rr_cnt[k]++;
      end
    end
  end

  task automatic pulse_start(int k);
    @(negedge clk); st[k] = 1'b1;
    @(negedge clk); st[k] = 1'b0;
  endtask

  task automatic pulse_pause(int k);
    @(negedge clk); pa[k] = 1'b1;
    @(negedge clk); pa[k] = 1'b0;
  endtask

  task automatic pulse_score(int k, logic [1:0] v, logic with_pause);
    @(negedge clk); sp[k] = v; pa[k] = with_pause;
    @(negedge clk); sp[k] = 2'b00; pa[k] = 1'b0;
  endtask

  task automatic ticks(int k, int n);
    repeat (n) begin
      @(negedge clk); ft[k] = 1'b1;
      @(negedge clk); ft[k] = 1'b0;
    end
  endtask

  // One point in a short-frame match, then back to PLAY via SERVE.
  task automatic rally(int k, logic [1:0] v);
    pulse_score(k, v, 1'b0);
    ticks(k, 2);
    ticks(k, 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rr_base;
    for (int k = 0; k < 3; k++) sp[k] = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset state", 32'(o_state[0]), 32'd0);
    chk("reset scores", 32'(o_sc0), 32'd0);
    chk("reset round_reset", 32'(o_rr[0]), 32'd0);
    chk("reset ball_enable", 32'(o_be[0]), 32'd0);
    chk("reset game_over", 32'(o_go[0]), 32'd0);
    chk("reset winner", 32'(o_win[0]), 32'd0);
    rst = 3'b000;

    // Default parameters: serve delay of 60 frames.
    rr_base = rr_cnt[0];
    pulse_start(0);
    chk("start->SERVE", 32'(o_state[0]), 32'd1);
    ticks(0, 59);
    chk("59 ticks still SERVE", 32'(o_state[0]), 32'd1);
    chk("59 ticks ball off", 32'(o_be[0]), 32'd0);
    ticks(0, 1);
    chk("60th tick PLAY", 32'(o_state[0]), 32'd2);
    chk("PLAY ball on", 32'(o_be[0]), 32'd1);
    chk("one round_reset pulse", 32'(rr_cnt[0] - rr_base), 32'd1);

    // Simultaneous points: lowest index credited.
    pulse_score(0, 2'b11, 1'b0);
    chk("both scored ->POINT", 32'(o_state[0]), 32'd3);
    chk("p0 credited", 32'(o_sc0[3:0]), 32'd1);
    chk("p1 not credited", 32'(o_sc0[7:4]), 32'd0);
    ticks(0, 29);
    chk("29 ticks still POINT", 32'(o_state[0]), 32'd3);
    ticks(0, 1);
    chk("POINT->SERVE", 32'(o_state[0]), 32'd1);
    chk("round_reset after POINT", 32'(o_rr[0]), 32'd1);
    @(negedge clk);
    chk("round_reset one cycle", 32'(o_rr[0]), 32'd0);

    // Pause racing a score, then a real pause.
    ticks(0, 60);
    pulse_score(0, 2'b01, 1'b1);
    chk("score beats pause", 32'(o_state[0]), 32'd3);
    chk("p0 now 2", 32'(o_sc0[3:0]), 32'd2);
    ticks(0, 30);
    ticks(0, 60);
    pulse_pause(0);
    chk("pause ->PAUSED", 32'(o_state[0]), 32'd4);
    pulse_score(0, 2'b10, 1'b0);
    ticks(0, 3);
    chk("PAUSED ignores score", 32'(o_sc0[7:4]), 32'd0);
    chk("PAUSED holds", 32'(o_state[0]), 32'd4);
    pulse_pause(0);
    chk("unpause ->PLAY", 32'(o_state[0]), 32'd2);
    pulse_start(0);
    chk("start ignored in PLAY", 32'(o_state[0]), 32'd2);
    chk("scores kept", 32'(o_sc0), 32'h02);

    // Win by two to three points.
    pulse_start(1);
    ticks(1, 2);
    rally(1, 2'b01); rally(1, 2'b10); rally(1, 2'b01);
    rally(1, 2'b10); rally(1, 2'b01); rally(1, 2'b10);
    chk("deuce 3:3", 32'(o_sc1), 32'h33);
    pulse_score(1, 2'b10, 1'b0);
    ticks(1, 2);
    chk("3:4 no win", 32'(o_state[1]), 32'd1);
    chk("3:4 scores", 32'(o_sc1), 32'h43);
    ticks(1, 2);
    pulse_score(1, 2'b10, 1'b0);
    ticks(1, 2);
    chk("3:5 OVER", 32'(o_state[1]), 32'd5);
    chk("3:5 game_over", 32'(o_go[1]), 32'd1);
    chk("3:5 winner", 32'(o_win[1]), 32'd1);
    pulse_pause(1);
    chk("pause ignored in OVER", 32'(o_state[1]), 32'd5);
    pulse_start(1);
    chk("restart SERVE", 32'(o_state[1]), 32'd1);
    chk("restart clears", 32'(o_sc1), 32'd0);
    chk("restart round_reset", 32'(o_rr[1]), 32'd1);

    // Two-bit counters saturate; reset lands mid-POINT.
    pulse_start(2);
    ticks(2, 2);
    for (int i = 0; i < 8; i++) rally(2, (i % 2 == 0) ? 2'b01 : 2'b10);
    chk("saturated 3:3", 32'(o_sc2), 32'hF);
    pulse_score(2, 2'b01, 1'b0);
    chk("saturated POINT", 32'(o_state[2]), 32'd3);
    chk("no wrap", 32'(o_sc2), 32'hF);
    ticks(2, 1);
    @(negedge clk); rst[2] = 1'b1;
    @(negedge clk); rst[2] = 1'b0;
    chk("mid-POINT reset state", 32'(o_state[2]), 32'd0);
    chk("mid-POINT reset scores", 32'(o_sc2), 32'd0);
    chk("mid-POINT reset outputs", {o_rr[2], o_be[2], o_go[2], o_win[2]}, 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of scoring players; legal range 2..4.
REQ-002 SHALL have parameter SCORE_W, default 4, width of each score counter.
REQ-003 SHALL have parameter WIN_SCORE, default 10, points needed to win; legal range 1..2^SCORE_W-1.
REQ-004 SHALL have parameter WIN_BY_TWO, default 0; 1 = winner must lead every other player by >=2.
REQ-005 SHALL have parameter SERVE_FRAMES, default 60, frame ticks spent in SERVE before play; legal >=1.
REQ-006 SHALL have parameter POINT_FRAMES, default 30, frame ticks spent in POINT after a score; legal >=1.
REQ-007 SHALL have port clk, input, 1, pixel clock; the block's only clock.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port start, input, 1, one-cycle pulse requesting a new match.
REQ-010 SHALL have port pause, input, 1, one-cycle pulse toggling pause.
REQ-011 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-012 SHALL have port score_pulse, input, NUM_PLAYERS, one bit per player, one-cycle point award.
REQ-013 SHALL have port scores, output, NUM_PLAYERS*SCORE_W, packed scores, player 0 in the LSBs.
REQ-014 SHALL have port round_reset, output, 1, one-cycle pulse re-centring ball and paddles.
REQ-015 SHALL have port ball_enable, output, 1, high only while state is PLAY.
REQ-016 SHALL have port game_over, output, 1, high only while state is OVER.
REQ-017 SHALL have port winner, output, 2, index of the winning player, valid while game_over=1.
REQ-018 SHALL have port state, output, 3, encoded state: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSED=4, OVER=5.

Function
REQ-019 SHALL register all outputs; ball_enable and game_over are decoded from the registered state.
REQ-020 IDLE: on start, SHALL clear all scores, pulse round_reset, and enter SERVE on the next cycle.
REQ-021 SERVE: SHALL count frame_tick pulses from 0, and on the SERVE_FRAMES-th tick SHALL enter PLAY.
REQ-022 PLAY: if any score_pulse bit is set, SHALL credit only the lowest-index set player (+1), then enter POINT.
REQ-023 PLAY: pause with no score_pulse SHALL enter PAUSED; if score_pulse and pause occur in the same cycle, the score wins and pause is dropped.
REQ-024 PAUSED: SHALL ignore score_pulse and frame_tick; pause SHALL return to PLAY with the score unchanged.
REQ-025 POINT: SHALL count POINT_FRAMES frame ticks, then evaluate the win condition on the updated scores.
REQ-026 Win condition SHALL be: score[i] >= WIN_SCORE, and when WIN_BY_TWO=1, score[i] >= score[j]+2 for every j != i; the lowest satisfying i wins.
REQ-027 POINT exit SHALL go to OVER with winner latched if the condition holds, else to SERVE with a one-cycle round_reset pulse.
REQ-028 OVER: scores and winner SHALL hold; start SHALL clear scores, pulse round_reset and enter SERVE.
REQ-029 start SHALL be ignored in SERVE, PLAY, POINT and PAUSED; pause SHALL be ignored outside PLAY and PAUSED.
REQ-030 Score counters SHALL saturate at 2^SCORE_W-1 and never wrap.
REQ-031 The frame counter SHALL clear on every state entry; a frame_tick in the entry cycle SHALL NOT be counted.
REQ-032 round_reset SHALL never be high for two consecutive cycles.

Reset
REQ-033 reset SHALL take priority over all inputs in any state.
REQ-034 Out of reset: state=IDLE, scores=0, winner=0, frame counter=0, round_reset=0, ball_enable=0, game_over=0.
REQ-035 reset mid-match SHALL discard scores and any pending round_reset, with no output glitch in the reset cycle.

Verification
REQ-036 Defaults: reset, start, 60 frame_ticks -> round_reset pulses once, state 0->1->2 with ball_enable=1 after the 60th tick.
REQ-037 PLAY, score_pulse=2'b11 -> scores[0]=1, scores[1]=0, state=POINT; after 30 ticks -> SERVE with round_reset pulse.
REQ-038 WIN_BY_TWO=1, WIN_SCORE=3, scores 3:3 then P1 scores -> 3:4, no win; P1 scores again -> 3:5, game_over=1, winner=1.
REQ-039 PLAY, pause and score_pulse[0] in the same cycle -> POINT and score +1; later pause in PLAY -> PAUSED, score_pulse ignored, pause -> PLAY.
REQ-040 SCORE_W=2, WIN_BY_TWO=1, repeated alternating points -> scores saturate at 3, no wrap; reset mid-POINT -> IDLE with all outputs 0.
